// File: rtl/nabp_shifter_multi.sv
// Fill/shift sequencer with multi-pixel fixed-point stepping, driving the mapper, line buffer and PE enables.
// Optional macro NABP_SHIFTER_STALL_EN adds the sc_stall freeze input.
module nabp_shifter_multi #(
  parameter int IMAGE_SIZE = 256,
  parameter int FILL_CNT   = 15,
  parameter int ACCU_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int MAX_STEP   = 3,
  parameter int LB_DELAY   = 1,
  parameter int PE_DELAY   = 2,
  parameter int DONE_DELAY = 2,
  localparam int STEP_W    = $clog2(MAX_STEP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sc_fill_kick,
  input  logic              sc_shift_kick,
  input  logic              sc_abort,
  input  logic [ACCU_W-1:0] sc_accu_base,
  input  logic [ACCU_W-1:0] sc_accu_init,
`ifdef NABP_SHIFTER_STALL_EN
  input  logic              sc_stall,
`endif
  output logic              sc_fill_done,
  output logic              sc_shift_done,
  output logic              sc_busy,
  output logic              sc_err,
  output logic              mp_kick,
  output logic              mp_done,
  output logic              mp_shift_en,
  output logic [STEP_W-1:0] mp_shift_amt,
  output logic              lb_clear,
  output logic              lb_shift_en,
  output logic [STEP_W-1:0] lb_shift_amt,
  output logic              sw_pe_en
);

  localparam int INT_W = ACCU_W - FRAC_W;
  localparam int CNT_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

  typedef enum logic [1:0] {READY, FILL, FILL_DONE, SHIFT} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [ACCU_W-1:0] accu, base, accu_next;
  logic [INT_W-1:0]  step, base_int;
  logic [STEP_W-1:0] amt_raw;
  logic              en_raw, cnt_zero, advance, stall, shift_kick_ok, err_cond;
  logic              fill_raw, shift_raw;
  logic [STEP_W:0]   lb_out;
  logic              pe_out;
  logic [1:0]        done_out;

`ifdef NABP_SHIFTER_STALL_EN
  assign stall = sc_stall;
`else
  assign stall = 1'b0;
`endif

  assign advance   = ~stall;
  assign cnt_zero  = (cnt == '0);
  assign accu_next = accu + base;
  // Integer-part difference modulo 2^INT_W, so an accumulator wrap still yields a forward step.
  assign step      = accu_next[ACCU_W-1:FRAC_W] - accu[ACCU_W-1:FRAC_W];
  assign base_int  = sc_accu_base[ACCU_W-1:FRAC_W];
  assign err_cond  = (32'(base_int) > MAX_STEP) ||
                     ((32'(base_int) == MAX_STEP) && (sc_accu_base[FRAC_W-1:0] != '0));
  assign shift_kick_ok = (state == FILL_DONE) && sc_shift_kick && !sc_abort && advance;

  always_comb begin
    state_next = state;
    en_raw     = 1'b0;
    amt_raw    = '0;
    case (state)
      READY:     if (sc_fill_kick) state_next = FILL;
      FILL: begin
        if (cnt_zero) begin
          state_next = FILL_DONE;
        end else begin
          en_raw  = 1'b1;
          amt_raw = STEP_W'(1);
        end
      end
      FILL_DONE: if (sc_shift_kick) state_next = SHIFT;
      SHIFT: begin
        if (cnt_zero) state_next = READY;
        en_raw  = (step != '0);
        amt_raw = (32'(step) > MAX_STEP) ? STEP_W'(MAX_STEP) : STEP_W'(step);
      end
    endcase
    if (sc_abort) state_next = READY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= READY;
    end else if (sc_abort || advance) begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= CNT_W'(FILL_CNT);
      accu <= '0;
      base <= '0;
    end else if (sc_abort) begin
      cnt <= CNT_W'(FILL_CNT);
    end else if (advance) begin
      case (state)
        READY:     cnt <= CNT_W'(FILL_CNT);
        FILL:      cnt <= cnt_zero ? CNT_W'(IMAGE_SIZE - 1) : cnt - CNT_W'(1);
        FILL_DONE: begin
          if (sc_shift_kick) begin
            accu <= sc_accu_init;
            base <= sc_accu_base;
          end
        end
        SHIFT: begin
          cnt  <= cnt_zero ? CNT_W'(FILL_CNT) : cnt - CNT_W'(1);
          accu <= accu_next;
        end
      endcase
    end
  end

  // Sticky until reset; abort deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      sc_err <= 1'b0;
    end else if (shift_kick_ok && err_cond) begin
      sc_err <= 1'b1;
    end
  end

  assign fill_raw  = (state == FILL)  && cnt_zero && advance && !sc_abort;
  assign shift_raw = (state == SHIFT) && cnt_zero && advance && !sc_abort;

  generate
    if (LB_DELAY == 0) begin : g_lb_comb
      assign lb_out = {en_raw, amt_raw};
    end else begin : g_lb_pipe
      logic [STEP_W:0] pipe [LB_DELAY];
      always_ff @(posedge clk) begin
        if (reset || sc_abort) begin
          for (int i = 0; i < LB_DELAY; i++) pipe[i] <= '0;
        end else if (advance) begin
          pipe[0] <= {en_raw, amt_raw};
          for (int i = 1; i < LB_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign lb_out = pipe[LB_DELAY-1];
    end

    if (PE_DELAY == 0) begin : g_pe_comb
      assign pe_out = (state == SHIFT);
    end else begin : g_pe_pipe
      logic pipe [PE_DELAY];
      always_ff @(posedge clk) begin
        if (reset || sc_abort) begin
          for (int i = 0; i < PE_DELAY; i++) pipe[i] <= 1'b0;
        end else if (advance) begin
          pipe[0] <= (state == SHIFT);
          for (int i = 1; i < PE_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign pe_out = pipe[PE_DELAY-1];
    end

    if (DONE_DELAY == 0) begin : g_done_comb
      assign done_out = {fill_raw, shift_raw};
    end else begin : g_done_pipe
      logic [1:0] pipe [DONE_DELAY];
      always_ff @(posedge clk) begin
        if (reset || sc_abort) begin
          for (int i = 0; i < DONE_DELAY; i++) pipe[i] <= '0;
        end else if (advance) begin
          pipe[0] <= {fill_raw, shift_raw};
          for (int i = 1; i < DONE_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign done_out = pipe[DONE_DELAY-1];
    end
  endgenerate

  assign mp_shift_en   = en_raw & advance;
  assign mp_shift_amt  = amt_raw;
  assign lb_shift_en   = lb_out[STEP_W] & advance;
  assign lb_shift_amt  = lb_out[STEP_W-1:0];
  assign sw_pe_en      = pe_out;
  assign sc_fill_done  = done_out[1];
  assign sc_shift_done = done_out[0];
  assign mp_done       = done_out[0];
  assign sc_busy       = (state != READY);
  assign mp_kick       = sc_fill_kick;
  assign lb_clear      = sc_fill_kick;

endmodule

// File: tb/tb_nabp_shifter_multi.sv
// Scoreboard bench for nabp_shifter_multi: a timeline model pushes expected output events, a negedge monitor pops them.
module tb_nabp_shifter_multi;

  localparam int IMAGE_SIZE = 8;
  localparam int FILL_CNT   = 3;
  localparam int ACCU_W     = 8;
  localparam int FRAC_W     = 4;
  localparam int MAX_STEP   = 3;
  localparam int LB_DELAY   = 1;
  localparam int PE_DELAY   = 2;
  localparam int DONE_DELAY = 2;
  localparam int STEP_W     = $clog2(MAX_STEP + 1);
  localparam int INT_W      = ACCU_W - FRAC_W;

  typedef struct {
    int cyc;
    int amt;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sc_fill_kick = 1'b0;
  logic              sc_shift_kick = 1'b0;
  logic              sc_abort = 1'b0;
  logic [ACCU_W-1:0] sc_accu_base = '0;
  logic [ACCU_W-1:0] sc_accu_init = '0;
`ifdef NABP_SHIFTER_STALL_EN
  logic              sc_stall = 1'b0;
`endif
  logic              sc_fill_done, sc_shift_done, sc_busy, sc_err;
  logic              mp_kick, mp_done, mp_shift_en, lb_clear, lb_shift_en, sw_pe_en;
  logic [STEP_W-1:0] mp_shift_amt, lb_shift_amt;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_on = 1'b0;
  ev_t mp_q[$], lb_q[$], pe_q[$], fd_q[$], sd_q[$];

  // Timeline model: READY from m_ready_from unless a fill is pending, FILL_DONE from m_fd_from.
  int  m_ready_from = 0;
  int  m_fd_from = 0;
  bit  m_in_fd = 1'b0;
  bit  m_err = 1'b0;

  nabp_shifter_multi #(
    .IMAGE_SIZE(IMAGE_SIZE), .FILL_CNT(FILL_CNT), .ACCU_W(ACCU_W), .FRAC_W(FRAC_W),
    .MAX_STEP(MAX_STEP), .LB_DELAY(LB_DELAY), .PE_DELAY(PE_DELAY), .DONE_DELAY(DONE_DELAY)
  ) dut (
    .clk(clk), .reset(reset),
    .sc_fill_kick(sc_fill_kick), .sc_shift_kick(sc_shift_kick), .sc_abort(sc_abort),
    .sc_accu_base(sc_accu_base), .sc_accu_init(sc_accu_init),
`ifdef NABP_SHIFTER_STALL_EN
    .sc_stall(sc_stall),
`endif
    .sc_fill_done(sc_fill_done), .sc_shift_done(sc_shift_done), .sc_busy(sc_busy),
    .sc_err(sc_err), .mp_kick(mp_kick), .mp_done(mp_done), .mp_shift_en(mp_shift_en),
    .mp_shift_amt(mp_shift_amt), .lb_clear(lb_clear), .lb_shift_en(lb_shift_en),
    .lb_shift_amt(lb_shift_amt), .sw_pe_en(sw_pe_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input int a);
    ev_t e;
    e.cyc = c;
    e.amt = a;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check_output(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic compare_event(input string name, input ev_t e, input int got);
    checks++;
    if (e.cyc != cyc || e.amt != got) begin
      failures++;
      $display("[TB] FAIL %s seen at cycle %0d value %0d, expected cycle %0d value %0d",
               name, cyc, got, e.cyc, e.amt);
    end
  endtask

  task automatic unexpected(input string name, input int got);
    checks++;
    failures++;
    $display("[TB] FAIL %s unexpected at cycle %0d value %0d, expected none", name, cyc, got);
  endtask

  // Abort or reset seen in cycle a cancels every event that would appear after it.
  task automatic purge(input int a);
    while (mp_q.size() > 0 && mp_q[$].cyc > a) void'(mp_q.pop_back());
    while (lb_q.size() > 0 && lb_q[$].cyc > a) void'(lb_q.pop_back());
    while (pe_q.size() > 0 && pe_q[$].cyc > a) void'(pe_q.pop_back());
    while (fd_q.size() > 0 && fd_q[$].cyc > a) void'(fd_q.pop_back());
    while (sd_q.size() > 0 && sd_q[$].cyc > a) void'(sd_q.pop_back());
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_busy"}, int'(sc_busy), 0);
    check_output({tag, "_err"}, int'(sc_err), int'(m_err));
    check_output({tag, "_mp_en"}, int'(mp_shift_en), 0);
    check_output({tag, "_mp_amt"}, int'(mp_shift_amt), 0);
    check_output({tag, "_lb"}, int'({lb_shift_en, lb_shift_amt}), 0);
    check_output({tag, "_pe"}, int'(sw_pe_en), 0);
    check_output({tag, "_done"}, int'({sc_fill_done, sc_shift_done, mp_done}), 0);
  endtask

  task automatic do_fill();
    int k;
    k = cyc;
    sc_fill_kick = 1'b1;
    #1;
    check_output("mp_kick", int'(mp_kick), 1);
    check_output("lb_clear", int'(lb_clear), 1);
    if (!m_in_fd && k >= m_ready_from) begin
      for (int i = 1; i <= FILL_CNT; i++) begin
        mp_q.push_back(mk(k + i, 1));
        lb_q.push_back(mk(k + i + LB_DELAY, 1));
      end
      fd_q.push_back(mk(k + 1 + FILL_CNT + DONE_DELAY, 0));
      m_in_fd      = 1'b1;
      m_fd_from    = k + 2 + FILL_CNT;
      m_ready_from = 1 << 30;
    end
    tick();
    sc_fill_kick = 1'b0;
  endtask

  task automatic do_shift(input int init, input int base);
    int j, a, nxt, step, amt;
    j = cyc;
    sc_shift_kick = 1'b1;
    sc_accu_init  = ACCU_W'(init);
    sc_accu_base  = ACCU_W'(base);
    if (m_in_fd && j >= m_fd_from) begin
      a = init;
      for (int i = 1; i <= IMAGE_SIZE; i++) begin
        nxt  = (a + base) % (1 << ACCU_W);
        step = ((nxt >> FRAC_W) - (a >> FRAC_W) + (1 << INT_W)) % (1 << INT_W);
        amt  = (step > MAX_STEP) ? MAX_STEP : step;
        if (step != 0) begin
          mp_q.push_back(mk(j + i, amt));
          lb_q.push_back(mk(j + i + LB_DELAY, amt));
        end
        pe_q.push_back(mk(j + i + PE_DELAY, 0));
        a = nxt;
      end
      sd_q.push_back(mk(j + IMAGE_SIZE + DONE_DELAY, 3));
      if (base > (MAX_STEP << FRAC_W)) m_err = 1'b1;
      m_in_fd      = 1'b0;
      m_ready_from = j + 1 + IMAGE_SIZE;
    end
    tick();
    sc_shift_kick = 1'b0;
    check_output("sc_err", int'(sc_err), int'(m_err));
  endtask

  task automatic do_abort();
    int a;
    a = cyc;
    sc_abort = 1'b1;
    purge(a);
    m_in_fd      = 1'b0;
    m_ready_from = a + 1;
    tick();
    sc_abort = 1'b0;
    check_output("abort_busy", int'(sc_busy), 0);
    check_output("abort_lb_en", int'(lb_shift_en), 0);
    check_output("abort_pe_en", int'(sw_pe_en), 0);
  endtask

  task automatic do_reset();
    int r;
    r = cyc;
    reset = 1'b1;
    purge(r);
    m_err        = 1'b0;
    m_in_fd      = 1'b0;
    m_ready_from = r + 1;
    tick();
    check_idle("reset");
    reset = 1'b0;
  endtask

  // action: 0 none, 1 abort, 2 stray fill kick during SHIFT; delay counts cycles after the first SHIFT cycle.
  task automatic apply_stimulus(input int init, input int base, input int action, input int delay);
    do_fill();
    wait_until(m_fd_from + int'($urandom_range(0, 2)));
    do_shift(init, base);
    check_output("shift_busy", int'(sc_busy), 1);
    if (action != 0) begin
      repeat (delay) tick();
      if (action == 1) do_abort();
      else do_fill();
    end
    wait_until(m_ready_from);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_on) begin
      if (mp_shift_en) begin
        if (mp_q.size() == 0) unexpected("mp_shift_en", int'(mp_shift_amt));
        else begin e = mp_q.pop_front(); compare_event("mp_shift_en", e, int'(mp_shift_amt)); end
      end else if (mp_shift_amt != '0) begin
        check_output("mp_amt_idle", int'(mp_shift_amt), 0);
      end
      if (lb_shift_en) begin
        if (lb_q.size() == 0) unexpected("lb_shift_en", int'(lb_shift_amt));
        else begin e = lb_q.pop_front(); compare_event("lb_shift_en", e, int'(lb_shift_amt)); end
      end
      if (sw_pe_en) begin
        if (pe_q.size() == 0) unexpected("sw_pe_en", 1);
        else begin e = pe_q.pop_front(); compare_event("sw_pe_en", e, 0); end
      end
      if (sc_fill_done) begin
        if (fd_q.size() == 0) unexpected("sc_fill_done", 1);
        else begin e = fd_q.pop_front(); compare_event("sc_fill_done", e, 0); end
      end
      if (sc_shift_done || mp_done) begin
        if (sd_q.size() == 0) unexpected("sc_shift_done", int'({mp_done, sc_shift_done}));
        else begin e = sd_q.pop_front(); compare_event("sc_shift_done", e, int'({mp_done, sc_shift_done})); end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tick();
    tick();
    check_idle("init");
    reset = 1'b0;
    m_ready_from = cyc;
    mon_on = 1'b1;

    $display("[TB] basic fill and unit-step shift");
    apply_stimulus(8'h00, 8'h10, 0, 0);

    $display("[TB] fractional step and saturating step");
    apply_stimulus(8'h00, 8'h28, 0, 0);
    apply_stimulus(8'h00, 8'h40, 0, 0);

    $display("[TB] reset mid-fill clears everything");
    do_fill();
    tick();
    do_reset();

    $display("[TB] shift kick in READY is ignored");
    do_shift(8'h00, 8'h50);
    check_output("ready_busy", int'(sc_busy), 0);

    $display("[TB] accumulator wrap");
    apply_stimulus(8'hF8, 8'h08, 0, 0);

    $display("[TB] abort in fourth shift cycle");
    apply_stimulus(8'h00, 8'h10, 1, 3);

    $display("[TB] fill kick during shift is ignored");
    apply_stimulus(8'h00, 8'h28, 2, 2);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 25; t++) begin
      int r;
      r = int'($urandom_range(0, 5));
      apply_stimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 8'h4F)),
                     (r == 0) ? 1 : ((r == 1) ? 2 : 0), int'($urandom_range(0, IMAGE_SIZE - 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (LB_DELAY + PE_DELAY + DONE_DELAY + 4) tick();
    check_output("mp_pending", mp_q.size(), 0);
    check_output("lb_pending", lb_q.size(), 0);
    check_output("pe_pending", pe_q.size(), 0);
    check_output("fill_done_pending", fd_q.size(), 0);
    check_output("shift_done_pending", sd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
